// File: rtl/osc_capture_pkg.sv
// Shared types and helpers for the oscilloscope capture engine.
// Holds the FSM state encoding, trigger-mode codes and a width helper.
package osc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  localparam logic [1:0] TRIG_RISE   = 2'b00;
  localparam logic [1:0] TRIG_FALL   = 2'b01;
  localparam logic [1:0] TRIG_EITHER = 2'b10;
  localparam logic [1:0] TRIG_AUTO   = 2'b11;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/osc_trig_detect.sv
// Edge/level trigger detector for one channel: remembers the previous written
// sample and raises a single-cycle trig pulse on a qualifying frame.
module osc_trig_detect
  import osc_capture_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                smp_vld_i,
  input  logic [SAMPLE_W-1:0] smp_i,
  input  logic [SAMPLE_W-1:0] level_i,
  input  logic [1:0]          mode_i,
  output logic                trig_o
);

  logic [SAMPLE_W-1:0] prev_q;
  logic                prev_vld_q;
  logic                cur_hi, prev_hi, rise, fall, hit;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (smp_vld_i) begin
      prev_q     <= smp_i;
      prev_vld_q <= 1'b1;
    end
  end

  always_comb begin
    cur_hi  = smp_i >= level_i;
    prev_hi = prev_q >= level_i;
    // Edge modes need a real previous sample; the first frame after arm has none.
    rise    = prev_vld_q && !prev_hi && cur_hi;
    fall    = prev_vld_q && prev_hi && !cur_hi;
    unique case (mode_i)
      TRIG_RISE:   hit = rise;
      TRIG_FALL:   hit = fall;
      TRIG_EITHER: hit = rise || fall;
      default:     hit = 1'b1;
    endcase
    trig_o = smp_vld_i && hit;
  end

endmodule

// File: rtl/osc_capture_engine.sv
// Multi-channel capture engine: decimates ADC frames, serialises kept frames
// into the on-chip RAM ring and records a pre/post-trigger window.
module osc_capture_engine
  import osc_capture_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 12,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int DECIM_W  = 16
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset,
  input  logic                           adc_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]     adc_data,
  input  logic                           cfg_arm,
  input  logic [clog2_min1(NUM_CH)-1:0]  cfg_trig_ch,
  input  logic [SAMPLE_W-1:0]            cfg_trig_level,
  input  logic [1:0]                     cfg_trig_mode,
  input  logic [ADDR_W-1:0]              cfg_pretrig,
  input  logic [DECIM_W-1:0]             cfg_decim,
  output logic [ADDR_W-1:0]              mem_address,
  output logic                           mem_chipselect,
  output logic                           mem_clken,
  output logic                           mem_write,
  output logic [DATA_W-1:0]              mem_writedata,
  output logic [DATA_W/8-1:0]            mem_byteenable,
  output logic [2:0]                     status_state,
  output logic [ADDR_W-1:0]              status_trig_addr,
  output logic                           status_done,
  output logic                           status_overrun
);

  localparam int TCH_W  = clog2_min1(NUM_CH);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int FRAMES = DEPTH / NUM_CH;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int SER_W  = $clog2(NUM_CH + 1);
  localparam logic [ADDR_W-1:0] PRE_MAX = ADDR_W'(FRAMES - 1);

  cap_state_e                       state_q, state_d;
  logic [TCH_W-1:0]                 tch_q, tch_d;
  logic [SAMPLE_W-1:0]              lvl_q, lvl_d;
  logic [1:0]                       mode_q, mode_d;
  logic [ADDR_W-1:0]                pre_q, pre_d;
  logic [DECIM_W-1:0]               decim_q, decim_d, dec_cnt_q, dec_cnt_d;
  logic [ADDR_W-1:0]                pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]                 post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]                wptr_q, wptr_d, trig_addr_q, trig_addr_d;
  logic [SER_W-1:0]                 ser_cnt_q, ser_cnt_d;
  logic [NUM_CH-1:0][DATA_W-1:0]    sh_q, sh_d;
  logic                             ovr_q, ovr_d, clken_q;

  logic [NUM_CH-1:0][SAMPLE_W-1:0]  smp;
  logic [CNT_W-1:0]                 post_tgt;
  logic [ADDR_W-1:0]                start_addr;
  logic writing, busy, pre_full, post_full, armed_now;
  logic frame_in, keep, load, trig, trig_hit;

  assign smp = adc_data;

  osc_trig_detect #(.SAMPLE_W(SAMPLE_W)) u_trig (
    .clk_i     (clk_clk),
    .rst_i     (reset_reset),
    .clr_i     (cfg_arm),
    .smp_vld_i (load),
    .smp_i     (smp[tch_q]),
    .level_i   (lvl_q),
    .mode_i    (mode_q),
    .trig_o    (trig)
  );

  always_comb begin
    writing    = ser_cnt_q != '0;
    // The last word of a frame frees the shifter, so a new frame may load then.
    busy       = ser_cnt_q > SER_W'(1);
    post_tgt   = CNT_W'(FRAMES) - {1'b0, pre_q};
    pre_full   = pre_cnt_q == pre_q;
    post_full  = post_cnt_q == post_tgt;
    armed_now  = (state_q == ST_ARMED) || (state_q == ST_PRE && pre_full);
    frame_in   = adc_valid && ((state_q == ST_PRE) || (state_q == ST_ARMED) ||
                               (state_q == ST_POST && !post_full));
    keep       = frame_in && (dec_cnt_q == decim_q);
    load       = keep && !busy;
    trig_hit   = trig && armed_now;
    start_addr = wptr_q + {{(ADDR_W-1){1'b0}}, writing};

    state_d     = state_q;
    tch_d       = tch_q;
    lvl_d       = lvl_q;
    mode_d      = mode_q;
    pre_d       = pre_q;
    decim_d     = decim_q;
    dec_cnt_d   = dec_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    wptr_d      = wptr_q;
    trig_addr_d = trig_addr_q;
    ser_cnt_d   = ser_cnt_q;
    sh_d        = sh_q;
    ovr_d       = ovr_q;

    if (writing) begin
      wptr_d    = wptr_q + ADDR_W'(1);
      ser_cnt_d = ser_cnt_q - SER_W'(1);
      for (int i = 0; i < NUM_CH - 1; i++) sh_d[i] = sh_q[i+1];
      sh_d[NUM_CH-1] = '0;
    end
    if (frame_in) dec_cnt_d = keep ? '0 : dec_cnt_q + DECIM_W'(1);
    if (keep && busy) ovr_d = 1'b1;
    if (load) begin
      ser_cnt_d = SER_W'(NUM_CH);
      for (int i = 0; i < NUM_CH; i++) sh_d[i] = DATA_W'(smp[i]);
      if (state_q == ST_PRE && !pre_full) pre_cnt_d = pre_cnt_q + ADDR_W'(1);
      if (state_q == ST_POST) post_cnt_d = post_cnt_q + CNT_W'(1);
      if (trig_hit) begin
        post_cnt_d  = CNT_W'(1);
        trig_addr_d = start_addr;
      end
    end

    unique case (state_q)
      ST_PRE: begin
        if (trig_hit) state_d = ST_POST;
        else if (pre_full && ser_cnt_q <= SER_W'(1)) state_d = ST_ARMED;
      end
      ST_ARMED: if (trig_hit) state_d = ST_POST;
      ST_POST:  if (post_full && ser_cnt_q == SER_W'(1)) state_d = ST_DONE;
      default:  state_d = state_q;
    endcase

    // Arm wins over everything, including a frame in flight.
    if (cfg_arm) begin
      state_d     = ST_PRE;
      tch_d       = cfg_trig_ch;
      lvl_d       = cfg_trig_level;
      mode_d      = cfg_trig_mode;
      pre_d       = (cfg_pretrig > PRE_MAX) ? PRE_MAX : cfg_pretrig;
      decim_d     = cfg_decim;
      dec_cnt_d   = '0;
      pre_cnt_d   = '0;
      post_cnt_d  = '0;
      wptr_d      = '0;
      trig_addr_d = '0;
      ser_cnt_d   = '0;
      ovr_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_IDLE;
      tch_q       <= '0;
      lvl_q       <= '0;
      mode_q      <= '0;
      pre_q       <= '0;
      decim_q     <= '0;
      dec_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      wptr_q      <= '0;
      trig_addr_q <= '0;
      ser_cnt_q   <= '0;
      sh_q        <= '0;
      ovr_q       <= 1'b0;
      clken_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tch_q       <= tch_d;
      lvl_q       <= lvl_d;
      mode_q      <= mode_d;
      pre_q       <= pre_d;
      decim_q     <= decim_d;
      dec_cnt_q   <= dec_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      wptr_q      <= wptr_d;
      trig_addr_q <= trig_addr_d;
      ser_cnt_q   <= ser_cnt_d;
      sh_q        <= sh_d;
      ovr_q       <= ovr_d;
      clken_q     <= 1'b1;
    end
  end

  assign mem_address      = wptr_q;
  assign mem_chipselect   = writing;
  assign mem_write        = writing;
  assign mem_clken        = clken_q;
  assign mem_writedata    = writing ? sh_q[0] : '0;
  assign mem_byteenable   = writing ? '1 : '0;
  assign status_state     = state_q;
  assign status_trig_addr = trig_addr_q;
  assign status_done      = state_q == ST_DONE;
  assign status_overrun   = ovr_q;

endmodule

// File: tb/tb_osc_capture_engine.sv
// Scoreboard bench for osc_capture_engine (2 channels, 512-word ring).
// Stimulus pushes expected RAM writes; a monitor thread pops them per write.
module tb_osc_capture_engine;

  logic        clk = 1'b0, rst = 1'b1;
  logic        adc_valid = 1'b0, cfg_arm = 1'b0;
  logic [23:0] adc_data = '0;
  logic [0:0]  cfg_trig_ch = '0;
  logic [11:0] cfg_trig_level = '0;
  logic [1:0]  cfg_trig_mode = '0;
  logic [8:0]  cfg_pretrig = '0;
  logic [15:0] cfg_decim = '0;
  logic [8:0]  mem_address, status_trig_addr;
  logic        mem_chipselect, mem_clken, mem_write, status_done, status_overrun;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic [2:0]  status_state;

  typedef struct { int a; int d; } exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0, wr_cnt = 0;

  always #5 clk = ~clk;

  osc_capture_engine dut (
    .clk_clk(clk), .reset_reset(rst), .adc_valid(adc_valid), .adc_data(adc_data),
    .cfg_arm(cfg_arm), .cfg_trig_ch(cfg_trig_ch), .cfg_trig_level(cfg_trig_level),
    .cfg_trig_mode(cfg_trig_mode), .cfg_pretrig(cfg_pretrig), .cfg_decim(cfg_decim),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .status_state(status_state), .status_trig_addr(status_trig_addr),
    .status_done(status_done), .status_overrun(status_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int base, input int c0, input int c1);
    sbq.push_back('{base % 512, c0 & 12'hFFF});
    sbq.push_back('{(base + 1) % 512, c1 & 12'hFFF});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_write) begin
        wr_cnt++;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write required", mem_address, mem_writedata);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", mem_address, e.a);
          chk("wr_data", mem_writedata, e.d);
          chk("wr_strobes", {mem_chipselect, mem_clken, mem_byteenable}, 4'hF);
        end
      end
    end
  endtask

  // One frame then three idle cycles; entered and left at posedge+1.
  task automatic frame(input int c0, input int c1, input bit wr, input int base);
    logic [11:0] a, b;
    a = c0[11:0]; b = c1[11:0];
    adc_data = {b, a};
    adc_valid = 1'b1;
    if (wr) push(base, c0, c1);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic arm(input int mode, input int ch, input int lvl, input int pre, input int dec);
    cfg_trig_mode = mode[1:0]; cfg_trig_ch = ch[0:0]; cfg_trig_level = lvl[11:0];
    cfg_pretrig = pre[8:0]; cfg_decim = dec[15:0];
    cfg_arm = 1'b1;
    @(posedge clk); #1;
    cfg_arm = 1'b0;
    chk("arm_state_pre", status_state, 1);
    chk("arm_done_clr", status_done, 0);
    chk("arm_wptr_zero", mem_address, 0);
    wr_cnt = 0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int c0, c1;
    logic [11:0] a, b;
    fork monitor(); join_none
    repeat (3) @(posedge clk); #1;
    chk("rst_state", status_state, 0);
    chk("rst_mem", {mem_write, mem_chipselect, mem_clken, mem_byteenable}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_status", {status_done, status_overrun, status_trig_addr}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_clken", mem_clken, 1);
    frame(12'h123, 12'h456, 0, 0);
    chk("idle_no_write", wr_cnt, 0);
    chk("idle_no_ovr", status_overrun, 0);

    // T1: auto trigger, no pre-trigger: 256 frames fill the whole ring.
    arm(3, 0, 0, 0, 0);
    for (int f = 0; f < 256; f++) begin
      frame(f, 12'hFFF - f, 1, 2 * f);
      if (f == 0) begin
        chk("t1_trig_addr", status_trig_addr, 0);
        chk("t1_post", status_state, 3);
      end
    end
    chk("t1_done_state", status_state, 4);
    chk("t1_done", status_done, 1);
    chk("t1_writes", wr_cnt, 512);
    chk("t1_wrap", mem_address, 0);
    chk("t1_sb_empty", sbq.size(), 0);
    frame(12'h321, 12'h654, 0, 0);
    chk("t1_done_ignored", wr_cnt, 512);
    chk("t1_done_no_ovr", status_overrun, 0);

    // T2: rising on ch0 at 0x800, 64 pre-trigger frames, ramp from frame 100.
    arm(0, 0, 12'h800, 64, 0);
    for (int f = 0; f < 308; f++) begin
      if (f < 100) c0 = 12'h100;
      else if (f < 132) c0 = 12'h700 + 16 * (f - 100);
      else c0 = 12'h900;
      frame(c0, f, 1, 2 * f);
      if (f == 62) chk("t2_still_pre", status_state, 1);
      if (f == 63) chk("t2_armed", status_state, 2);
      if (f == 116) begin
        chk("t2_trig_addr", status_trig_addr, 232);
        chk("t2_post", status_state, 3);
      end
    end
    chk("t2_done", status_done, 1);
    chk("t2_writes", wr_cnt, 616);
    chk("t2_trig_hold", status_trig_addr, 232);
    chk("t2_sb_empty", sbq.size(), 0);

    // T3: falling on ch1 at 0x400; crossing at frame 3 lies inside PRE.
    arm(1, 1, 12'h400, 8, 0);
    for (int f = 0; f < 258; f++) begin
      c1 = (f == 3 || f == 4 || f >= 10) ? 12'h300 : 12'h500;
      frame(f, c1, 1, 2 * f);
      if (f == 4) chk("t3_pre_ignored", status_state, 1);
      if (f == 9) chk("t3_armed_wait", status_state, 2);
      if (f == 10) chk("t3_trig_addr", status_trig_addr, 20);
    end
    chk("t3_done", status_done, 1);
    chk("t3_writes", wr_cnt, 516);
    chk("t3_sb_empty", sbq.size(), 0);

    // T4: decimate by 4; frames 3,7,11,15 are kept.
    arm(3, 0, 0, 0, 3);
    for (int f = 0; f < 16; f++) frame(f + 16, f + 32, (f % 4) == 3, 2 * (f / 4));
    chk("t4_writes", wr_cnt, 8);
    chk("t4_state", status_state, 3);
    chk("t4_sb_empty", sbq.size(), 0);

    // T5: back-to-back frames; odd ones collide with the shifter.
    arm(3, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      a = 12'(64 + i); b = 12'(80 + i);
      adc_data = {b, a};
      adc_valid = 1'b1;
      if (i % 2 == 0) push(i, 64 + i, 80 + i);
      @(posedge clk); #1;
    end
    adc_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("t5_overrun", status_overrun, 1);
    chk("t5_writes", wr_cnt, 6);
    chk("t5_sb_empty", sbq.size(), 0);
    chk("t6_in_post", status_state, 3);

    // T6: re-arm mid-POST, then reset mid-capture.
    arm(3, 0, 0, 0, 0);
    chk("t6_ovr_clr", status_overrun, 0);
    frame(12'h011, 12'h022, 1, 0);
    chk("t6_post_again", status_state, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_state", status_state, 0);
    chk("t6_rst_mem", {mem_write, mem_chipselect, mem_clken, mem_byteenable, mem_writedata}, 0);
    chk("t6_rst_status", {status_done, status_overrun, status_trig_addr, mem_address}, 0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("final_sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
